arb2_mux_tuple_bit_bits2: RTL and testbench
===========================================

Name: arb2_mux_tuple_bit_bits2

Overview:
- Round-robin arbiter/scheduler that shares one 2:1 tuple mux datapath (Bit flag + Bits(W) payload) between two valid/ready requesters.
- Field 0 of the tuple is a "last" flag. A multi-beat transfer holds the grant until its last beat (packet lock).
- Winner's tuple is driven through the mux select and captured in a single output register stage with valid/ready back-pressure.
- Sits between two upstream producers and one downstream consumer in the Main-level datapath.

Parameters:
- W, 2, payload width of tuple field 1.
- LOCK_ON_LAST, 1, 1 = hold grant until a beat with flag=1 is accepted; 0 = re-arbitrate after every accepted beat.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESETN  in  1  asynchronous active-low reset.
- I0_valid  in  1  requester 0 beat valid.
- I0__0  in  1  requester 0 last flag.
- I0__1  in  W  requester 0 payload.
- I0_ready  out  1  requester 0 beat accepted this cycle.
- I1_valid  in  1  requester 1 beat valid.
- I1__0  in  1  requester 1 last flag.
- I1__1  in  W  requester 1 payload.
- I1_ready  out  1  requester 1 beat accepted this cycle.
- O_valid  out  1  output register holds a beat.
- O__0  out  1  registered last flag.
- O__1  out  W  registered payload.
- O_ready  in  1  downstream accepts beat.
- O_src  out  1  requester index of the beat in the output register.
- S  out  1  current mux select (combinational grant, for debug/observation).

Behaviour:
- Reset (ASYNCRESETN=0, takes effect immediately, independent of CLK):
  - O_valid=0, O__0=0, O__1=0, O_src=0.
  - state=IDLE, priority pointer prio=0.
- Reset release is synchronous to CLK. The first arbitration happens on the first rising edge with ASYNCRESETN=1.
- Reset mid-packet discards the lock, the pending output beat, and prio. No beat is replayed.
- load = !O_valid || O_ready. The output stage is a pass-through register, so full throughput is 1 beat/cycle.
- States:
  - IDLE: unlocked.
  - LOCK0: granted to requester 0.
  - LOCK1: granted to requester 1.
- Grant selection (combinational):
  - LOCK0 → 0.
  - LOCK1 → 1.
  - IDLE:
    - only one valid → that one;
    - both valid → prio;
    - none valid → S=prio, no grant.
- Ready signals:
  - Ix_ready = load && grant==x && (state != LOCKy for y≠x).
  - Ready may depend combinationally on both valids.
  - In IDLE, the non-granted requester sees ready=0.
- Accept: when Ix_valid && Ix_ready at the clock edge, the output register loads {Ix__0, Ix__1}, O_valid=1, O_src=x.
- If load=1 and no accept occurs, O_valid→0. O__0, O__1 and O_src hold their last values.
- State transitions, on an accepted beat from x:
  - flag=1, or LOCK_ON_LAST=0 → state=IDLE, prio=!x (fairness flip).
  - flag=0 and LOCK_ON_LAST=1 → state=LOCKx, prio unchanged.
- In LOCKx with Ix_valid=0, the lock is held (bubble). The other requester is starved until x sends its last beat.
- Back-pressure: with O_valid=1 and O_ready=0, both readies are 0 and all state and output registers hold.
- Data width: mux and register are exactly 1+W bits. No truncation or extension.
- Latency: 1 cycle from input accept to O_valid.

Test Plan:
- Reset hold: ASYNCRESETN=0 asserted mid-cycle while O_valid=1.
  - O_valid=0, O__1=0 immediately, without a clock edge.
  - After release, the first grant with both valid goes to I0.
- Single beats, both valid every cycle, all flags=1, O_ready=1, I0__1=2'b01, I1__1=2'b10.
  - O__1 sequence 01,10,01,10 starting 1 cycle after the first edge.
  - O_src alternates 0,1,0,1.
- Packet lock, I0 sends 3 beats (flags 0,0,1; payloads 00,01,11) with I1 valid throughout (payload 10).
  - Output 00,01,11 from src 0, then 10 from src 1.
  - I1_ready=0 during the lock.
- Lock bubble: I0 sends flag=0, then drops valid for 2 cycles while I1 is valid.
  - I1_ready stays 0, O_valid=0 for those 2 cycles.
  - I0's next flag=1 beat is output, then I1 is granted.
- Back-pressure: O_ready=0 for 3 cycles with O_valid=1.
  - O__0, O__1, O_src stable; I0_ready=I1_ready=0.
  - The beat completes on the cycle O_ready returns to 1; a new beat loads the same edge.
- LOCK_ON_LAST=0 with I0 flags all 0 and both valid.
  - Grants alternate 0,1,0,1; no lock is ever entered.

Source files
------------

// File: rtl/arb2_mux_tuple_bit_bits2.sv
// ---------------------------------------------------------------------------
// arb2_mux_tuple_bit_bits2 : two-requester round-robin arbiter with packet
// lock, feeding a shared {last, payload} mux into one output register stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb2_mux_tuple_bit_bits2 #(
  parameter int W            = 2,
  parameter bit LOCK_ON_LAST = 1'b1
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic         I0_valid,
  input  logic         I0__0,
  input  logic [W-1:0] I0__1,
  output logic         I0_ready,
  input  logic         I1_valid,
  input  logic         I1__0,
  input  logic [W-1:0] I1__1,
  output logic         I1_ready,
  output logic         O_valid,
  output logic         O__0,
  output logic [W-1:0] O__1,
  input  logic         O_ready,
  output logic         O_src,
  output logic         S
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           prio;
  logic           prio_nxt;
  logic           grant;
  logic           load;
  logic           accept;
  logic           sel_flag;
  logic [W-1:0]   sel_data;

  // A lock pins the grant; otherwise a lone requester wins and ties go to prio.
  always_comb begin
    grant = prio;
    case (state)
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: begin
        if (I0_valid && !I1_valid)      grant = 1'b0;
        else if (I1_valid && !I0_valid) grant = 1'b1;
        else                            grant = prio;
      end
    endcase
  end

  assign load     = !O_valid || O_ready;
  assign I0_ready = load && !grant && (state != LOCK1);
  assign I1_ready = load &&  grant && (state != LOCK0);
  assign accept   = (I0_valid && I0_ready) || (I1_valid && I1_ready);
  assign sel_flag = grant ? I1__0 : I0__0;
  assign sel_data = grant ? I1__1 : I0__1;
  assign S        = grant;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    if (accept) begin
      if (sel_flag || !LOCK_ON_LAST) begin
        state_nxt = IDLE;
        prio_nxt  = !grant;
      end else begin
        state_nxt = grant ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state   <= IDLE;
      prio    <= 1'b0;
      O_valid <= 1'b0;
      O__0    <= 1'b0;
      O__1    <= '0;
      O_src   <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      if (accept) begin
        O_valid <= 1'b1;
        O__0    <= sel_flag;
        O__1    <= sel_data;
        O_src   <= grant;
      end else if (load) begin
        // Data fields keep their last value when the stage drains empty.
        O_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb2_mux_tuple_bit_bits2.sv
// ---------------------------------------------------------------------------
// tb_arb2_mux_tuple_bit_bits2 : directed self-checking bench for the arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arb2_mux_tuple_bit_bits2;

  logic       clk;
  logic       rst_n;
  logic       i0_valid, i0_flag, i1_valid, i1_flag, o_ready;
  logic [1:0] i0_data, i1_data;
  logic       i0_ready, i1_ready, o_valid, o_flag, o_src, s;
  logic [1:0] o_data;
  logic       n_i0_ready, n_i1_ready, n_o_valid, n_o_flag, n_o_src, n_s;
  logic [1:0] n_o_data;

  int checks   = 0;
  int failures = 0;

  arb2_mux_tuple_bit_bits2 #(.W(2), .LOCK_ON_LAST(1'b1)) u_dut (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .I0_valid(i0_valid), .I0__0(i0_flag), .I0__1(i0_data), .I0_ready(i0_ready),
    .I1_valid(i1_valid), .I1__0(i1_flag), .I1__1(i1_data), .I1_ready(i1_ready),
    .O_valid(o_valid), .O__0(o_flag), .O__1(o_data), .O_ready(o_ready),
    .O_src(o_src), .S(s)
  );

  arb2_mux_tuple_bit_bits2 #(.W(2), .LOCK_ON_LAST(1'b0)) u_dut_nl (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .I0_valid(i0_valid), .I0__0(i0_flag), .I0__1(i0_data), .I0_ready(n_i0_ready),
    .I1_valid(i1_valid), .I1__0(i1_flag), .I1__1(i1_data), .I1_ready(n_i1_ready),
    .O_valid(n_o_valid), .O__0(n_o_flag), .O__1(n_o_data), .O_ready(o_ready),
    .O_src(n_o_src), .S(n_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i0_valid = 0; i0_flag = 0; i0_data = 0;
    i1_valid = 0; i1_flag = 0; i1_data = 0;
    o_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 2'b00 || o_flag !== 1'b0 || o_src !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b flag=%b data=%b src=%b required 0 0 00 0", o_valid, o_flag, o_data, o_src);
    end
    i0_valid = 1; i0_flag = 1; i0_data = 2'b11; o_ready = 0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 2'b11) begin
      failures++;
      $display("FAIL reset_preload: valid=%b data=%b required 1 11", o_valid, o_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 2'b00 || o_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: valid=%b flag=%b data=%b required 0 0 00", o_valid, o_flag, o_data);
    end
    #1 rst_n = 1'b1;
    i0_data = 2'b01; i1_valid = 1; i1_flag = 1; i1_data = 2'b10; o_ready = 1;
    #1;
    checks++;
    if (s !== 1'b0 || i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_grant: S=%b r0=%b r1=%b required 0 1 0", s, i0_ready, i1_ready);
    end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 2'b01 || o_src !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_beat: valid=%b data=%b src=%b required 1 01 0", o_valid, o_data, o_src);
    end
  endtask

  task automatic test_single_beats();
    logic [1:0] exp_data [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic       exp_src  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    i0_valid = 1; i0_flag = 1; i0_data = 2'b01;
    i1_valid = 1; i1_flag = 1; i1_data = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp_data[i] || o_src !== exp_src[i] || o_flag !== 1'b1) begin
        failures++;
        $display("FAIL single_beat[%0d]: valid=%b data=%b src=%b flag=%b required 1 %b %b 1", i, o_valid, o_data, o_src, o_flag, exp_data[i], exp_src[i]);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic       flags [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] datas [3] = '{2'b00, 2'b01, 2'b11};
    do_reset();
    i1_valid = 1; i1_flag = 1; i1_data = 2'b10;
    i0_valid = 1;
    for (int i = 0; i < 3; i++) begin
      i0_flag = flags[i]; i0_data = datas[i];
      #1;
      checks++;
      if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
        failures++;
        $display("FAIL lock_ready[%0d]: r0=%b r1=%b required 1 0", i, i0_ready, i1_ready);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== datas[i] || o_src !== 1'b0 || o_flag !== flags[i]) begin
        failures++;
        $display("FAIL lock_beat[%0d]: valid=%b data=%b src=%b flag=%b required 1 %b 0 %b", i, o_valid, o_data, o_src, o_flag, datas[i], flags[i]);
      end
    end
    i0_valid = 0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 2'b10 || o_src !== 1'b1) begin
      failures++;
      $display("FAIL lock_release: valid=%b data=%b src=%b required 1 10 1", o_valid, o_data, o_src);
    end
  endtask

  task automatic test_lock_bubble();
    do_reset();
    i1_valid = 1; i1_flag = 1; i1_data = 2'b10;
    i0_valid = 1; i0_flag = 0; i0_data = 2'b01;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 2'b01 || o_src !== 1'b0) begin
      failures++;
      $display("FAIL bubble_first: valid=%b data=%b src=%b required 1 01 0", o_valid, o_data, o_src);
    end
    i0_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (i1_ready !== 1'b0 || s !== 1'b0) begin
        failures++;
        $display("FAIL bubble_ready[%0d]: r1=%b S=%b required 0 0", i, i1_ready, s);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
        failures++;
        $display("FAIL bubble_empty[%0d]: valid=%b required 0", i, o_valid);
      end
    end
    i0_valid = 1; i0_flag = 1; i0_data = 2'b11;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 2'b11 || o_src !== 1'b0 || o_flag !== 1'b1) begin
      failures++;
      $display("FAIL bubble_last: valid=%b data=%b src=%b flag=%b required 1 11 0 1", o_valid, o_data, o_src, o_flag);
    end
    i0_valid = 0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 2'b10 || o_src !== 1'b1) begin
      failures++;
      $display("FAIL bubble_other: valid=%b data=%b src=%b required 1 10 1", o_valid, o_data, o_src);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    i0_valid = 1; i0_flag = 1; i0_data = 2'b01;
    i1_valid = 1; i1_flag = 1; i1_data = 2'b10;
    tick();
    o_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready[%0d]: r0=%b r1=%b required 0 0", i, i0_ready, i1_ready);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 2'b01 || o_flag !== 1'b1 || o_src !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%b flag=%b src=%b required 1 01 1 0", i, o_valid, o_data, o_flag, o_src);
      end
    end
    o_ready = 1;
    #1;
    checks++;
    if (i1_ready !== 1'b1 || i0_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_resume_ready: r0=%b r1=%b required 0 1", i0_ready, i1_ready);
    end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 2'b10 || o_src !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume_beat: valid=%b data=%b src=%b required 1 10 1", o_valid, o_data, o_src);
    end
  endtask

  task automatic test_no_lock();
    logic [1:0] exp_data [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic       exp_src  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    i0_valid = 1; i0_flag = 0; i0_data = 2'b01;
    i1_valid = 1; i1_flag = 0; i1_data = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (n_o_valid !== 1'b1 || n_o_data !== exp_data[i] || n_o_src !== exp_src[i] || n_o_flag !== 1'b0) begin
        failures++;
        $display("FAIL nolock_beat[%0d]: valid=%b data=%b src=%b flag=%b required 1 %b %b 0", i, n_o_valid, n_o_data, n_o_src, n_o_flag, exp_data[i], exp_src[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_beats();
    test_packet_lock();
    test_lock_bubble();
    test_back_pressure();
    test_no_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
